// File: rtl/rumble_pwm.sv
// Cartridge-port rumble driver: PWM intensity, timed pulses, start-up kick and
// a continuous-on limit that forces a cooldown before the motor may restart.
module rumble_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int TICK_CYCLES = 74250,
  parameter int KICK_MS     = 20,
  parameter int MAX_ON_MS   = 5000,
  parameter int COOLDOWN_MS = 1000
) (
  input  logic                clk_74a,
  input  logic                reset,
  input  logic                active,
  input  logic [PWM_BITS-1:0] intensity,
  input  logic                pulse_start,
  input  logic [15:0]         pulse_ms,
  output logic                busy,
  output logic                cooldown,
  output wire  [7:4]          cart_tran_bank0,
  output logic                cart_tran_bank0_dir,
  output wire  [7:0]          cart_tran_bank1,
  output logic                cart_tran_bank1_dir,
  output wire  [7:0]          cart_tran_bank2,
  output logic                cart_tran_bank2_dir,
  output wire  [7:0]          cart_tran_bank3,
  output logic                cart_tran_bank3_dir
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int KW = (KICK_MS > 0)     ? $clog2(KICK_MS + 1) : 1;
  localparam int OW = (MAX_ON_MS > 0)   ? $clog2(MAX_ON_MS + 1) : 1;
  localparam int CW = (COOLDOWN_MS > 0) ? $clog2(COOLDOWN_MS + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [KW-1:0] KICK_END  = KW'(KICK_MS);
  localparam logic [OW-1:0] ON_END    = OW'(MAX_ON_MS);
  localparam logic [CW-1:0] CD_END    = CW'(COOLDOWN_MS);

  typedef enum logic [1:0] {S_IDLE, S_KICK, S_RUN, S_COOL} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [15:0]          pulse_rem_q, pulse_rem_d;
  logic [KW-1:0]        kick_cnt_q, kick_cnt_d;
  logic [OW-1:0]        on_cnt_q, on_cnt_d;
  logic [CW-1:0]        cd_cnt_q, cd_cnt_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic                 wr_n_q, wr_n_d;
  logic                 ad1_q, ad1_d;
  logic                 busy_q, busy_d;
  logic                 cooldown_q, cooldown_d;

  logic tick;
  logic demand;
  logic drive_on;

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign demand   = (active | (pulse_rem_q != 16'd0)) & (intensity != '0);
  assign drive_on = (state_q == S_KICK) |
                    ((state_q == S_RUN) & (pwm_cnt_q < intensity));

  // Timebase, pulse timer and PWM ramp run regardless of FSM state.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    pulse_rem_d = pulse_rem_q;
    if (pulse_start)
      pulse_rem_d = pulse_ms;
    else if (tick && pulse_rem_q != 16'd0)
      pulse_rem_d = pulse_rem_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (demand) state_d = (KICK_MS == 0) ? S_RUN : S_KICK;
      S_KICK: begin
        if (!demand)                  state_d = S_IDLE;
        else if (on_cnt_q == ON_END)  state_d = S_COOL;
        else if (kick_cnt_q == KICK_END) state_d = S_RUN;
      end
      S_RUN: begin
        if (!demand)                  state_d = S_IDLE;
        else if (on_cnt_q == ON_END)  state_d = S_COOL;
      end
      S_COOL: if (cd_cnt_q == CD_END) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Each counter is held at zero outside its own state(s), so it starts from
  // zero on entry; on_cnt spans KICK and RUN so it carries across KICK->RUN.
  always_comb begin
    kick_cnt_d = '0;
    on_cnt_d   = '0;
    cd_cnt_d   = '0;
    if (state_q == S_KICK)
      kick_cnt_d = (tick && kick_cnt_q != KICK_END) ? kick_cnt_q + 1'b1 : kick_cnt_q;
    if (state_q == S_KICK || state_q == S_RUN)
      on_cnt_d = (tick && on_cnt_q != ON_END) ? on_cnt_q + 1'b1 : on_cnt_q;
    if (state_q == S_COOL)
      cd_cnt_d = (tick && cd_cnt_q != CD_END) ? cd_cnt_q + 1'b1 : cd_cnt_q;
  end

  always_comb begin
    wr_n_d     = ~drive_on;
    ad1_d      = drive_on ? ~ad1_q : 1'b0;
    busy_d     = (state_q != S_IDLE);
    cooldown_d = (state_q == S_COOL);
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      pulse_rem_q <= '0;
      kick_cnt_q  <= '0;
      on_cnt_q    <= '0;
      cd_cnt_q    <= '0;
      pwm_cnt_q   <= '0;
      wr_n_q      <= 1'b1;
      ad1_q       <= 1'b0;
      busy_q      <= 1'b0;
      cooldown_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      pulse_rem_q <= pulse_rem_d;
      kick_cnt_q  <= kick_cnt_d;
      on_cnt_q    <= on_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      wr_n_q      <= wr_n_d;
      ad1_q       <= ad1_d;
      busy_q      <= busy_d;
      cooldown_q  <= cooldown_d;
    end
  end

  assign busy     = busy_q;
  assign cooldown = cooldown_q;

  assign cart_tran_bank0 = {1'bz, wr_n_q, 2'bzz};
  assign cart_tran_bank1 = 8'hzz;
  assign cart_tran_bank2 = 8'hzz;
  assign cart_tran_bank3 = {6'bzzzzzz, ad1_q, 1'bz};

  assign cart_tran_bank0_dir = 1'b1;
  assign cart_tran_bank1_dir = 1'b0;
  assign cart_tran_bank2_dir = 1'b0;
  assign cart_tran_bank3_dir = 1'b1;

endmodule

// File: tb/tb_rumble_pwm.sv
// Randomised + directed bench for rumble_pwm; a per-edge reference model feeds
// a queue of expected pin/status values that a negedge monitor drains.
module tb_rumble_pwm;
  localparam int PB = 4;
  localparam int TC = 10;
  localparam int KM = 2;
  localparam int MO = 20;
  localparam int CD = 5;

  logic          clk_74a = 1'b0;
  logic          reset = 1'b1;
  logic          active = 1'b0;
  logic [PB-1:0] intensity = '0;
  logic          pulse_start = 1'b0;
  logic [15:0]   pulse_ms = '0;
  wire           busy, cooldown;
  wire  [7:4]    b0;
  wire  [7:0]    b1, b2, b3;
  wire           b0d, b1d, b2d, b3d;

  int n_cmp = 0;
  int n_bad = 0;

  rumble_pwm #(.PWM_BITS(PB), .TICK_CYCLES(TC), .KICK_MS(KM),
               .MAX_ON_MS(MO), .COOLDOWN_MS(CD)) dut (
    .clk_74a(clk_74a), .reset(reset), .active(active), .intensity(intensity),
    .pulse_start(pulse_start), .pulse_ms(pulse_ms),
    .busy(busy), .cooldown(cooldown),
    .cart_tran_bank0(b0), .cart_tran_bank0_dir(b0d),
    .cart_tran_bank1(b1), .cart_tran_bank1_dir(b1d),
    .cart_tran_bank2(b2), .cart_tran_bank2_dir(b2d),
    .cart_tran_bank3(b3), .cart_tran_bank3_dir(b3d)
  );

  always #5 clk_74a = ~clk_74a;

  // Reference model: time measured in edges since reset; mode 0..3 =
  // idle/kick/run/cooldown, with elapsed-tick counts per phase.
  int m_mode = 0, m_kick = 0, m_on = 0, m_cd = 0, m_pulse = 0, m_k = 0;
  bit m_ad1 = 1'b0;
  logic [3:0] exp_q[$];

  always @(posedge clk_74a) begin
    logic [3:0] e;
    bit tk, drv, dem;
    int pwm;
    if (reset) begin
      m_mode = 0; m_kick = 0; m_on = 0; m_cd = 0; m_pulse = 0; m_k = 0;
      m_ad1 = 1'b0;
      e = 4'b1000;
    end else begin
      tk  = (m_k % TC) == TC - 1;
      pwm = m_k % (1 << PB);
      m_k++;
      dem = (active || m_pulse != 0) && intensity != 0;
      drv = (m_mode == 1) || (m_mode == 2 && pwm < int'(intensity));
      m_ad1 = drv ? !m_ad1 : 1'b0;
      e = {!drv, m_ad1, m_mode != 0, m_mode == 3};
      case (m_mode)
        0: begin
          m_kick = 0; m_on = 0;
          if (dem) m_mode = (KM == 0) ? 2 : 1;
        end
        1, 2: begin
          if (!dem) m_mode = 0;
          else if (m_on >= MO) begin m_mode = 3; m_cd = 0; end
          else if (m_mode == 1 && m_kick >= KM) m_mode = 2;
          if (tk) begin m_on++; m_kick++; end
        end
        default: begin
          if (m_cd >= CD) m_mode = 0;
          if (tk) m_cd++;
        end
      endcase
      if (pulse_start) m_pulse = int'(pulse_ms);
      else if (tk && m_pulse != 0) m_pulse--;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk_74a) begin
    logic [3:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {b0[6], b3[1], busy, cooldown};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL pins {wr_n,ad1,busy,cool} at %0t: got %b want %b", $time, a, e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_74a);
    #1;
  endtask

  task automatic wait_sig(input int sel, input logic val, input int lim, input string nm);
    bit hit = 1'b0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge clk_74a);
      hit = ((sel == 0) ? busy : cooldown) === val;
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL %s: got no %b within %0d cycles, want %b", nm, val, lim, val);
    end
  endtask

  initial begin
    cyc(3);
    @(negedge clk_74a);
    n_cmp++;
    if ({b0d, b1d, b2d, b3d} !== 4'b1001) begin
      n_bad++;
      $display("FAIL dir_pins: got %b want 1001", {b0d, b1d, b2d, b3d});
    end
    reset = 1'b0;

    // Kick then PWM at intensity 4
    active = 1'b1; intensity = 4'd4;
    wait_sig(0, 1'b1, 5, "kick_busy");
    cyc(60);
    active = 1'b0;
    wait_sig(0, 1'b0, 5, "release");

    // Timed pulse, then a cancelled pulse
    intensity = 4'd15; pulse_ms = 16'd7; pulse_start = 1'b1;
    cyc(1);
    pulse_start = 1'b0;
    wait_sig(0, 1'b1, 4, "pulse_busy");
    wait_sig(0, 1'b0, 90, "pulse_end");
    pulse_start = 1'b1;
    cyc(1);
    pulse_start = 1'b0;
    cyc(30);
    pulse_ms = 16'd0; pulse_start = 1'b1;
    cyc(1);
    pulse_start = 1'b0;
    wait_sig(0, 1'b0, 3, "pulse_cancel");

    // Safety limit and restart after cooldown
    intensity = 4'd8; active = 1'b1;
    wait_sig(1, 1'b1, 300, "cool_on");
    wait_sig(1, 1'b0, 80, "cool_off");
    wait_sig(0, 1'b1, 3, "rekick");
    active = 1'b0;
    wait_sig(0, 1'b0, 5, "idle_again");

    // Zero intensity never starts the motor
    intensity = 4'd0; active = 1'b1;
    cyc(40);

    // Drop active during KICK
    intensity = 4'd5;
    wait_sig(0, 1'b1, 5, "kick2_busy");
    active = 1'b0;
    wait_sig(0, 1'b0, 4, "kick_drop");

    // Reset asserted in RUN
    active = 1'b1;
    cyc(40);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    wait_sig(0, 1'b0, 1, "reset_run");

    // Randomised traffic
    repeat (4000) begin
      cyc(1);
      if ($urandom_range(0, 39) == 0) active = ~active;
      if ($urandom_range(0, 59) == 0)
        intensity = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
      pulse_ms    = 16'($urandom_range(0, 12));
      pulse_start = ($urandom_range(0, 99) == 0);
      reset       = ($urandom_range(0, 1499) == 0);
    end
    reset = 1'b0; pulse_start = 1'b0;
    cyc(3);
    @(negedge clk_74a);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rumble_pwm.md
# rumble_pwm

Parametrised cartridge-port rumble driver. It generalises the fixed on/off rumble enable with several additions: PWM intensity control, timed one-shot pulses, a full-power kick phase at motor start, and a thermal/power safety limit with forced cooldown. It sits between core logic (game-side rumble requests) and the Pocket cartridge transceiver banks. It drives WR_n (bank0 bit 6) and the AD1 motor carrier (bank3 bit 1), and leaves every other cart pin tri-stated.

## Interface
Parameters:
- PWM_BITS, 8: width of intensity and PWM counter; PWM period = 2^PWM_BITS cycles.
- TICK_CYCLES, 74250: clk_74a cycles per timebase tick (1 ms at 74.25 MHz).
- KICK_MS, 20: ticks of full drive on every start; 0 disables kick.
- MAX_ON_MS, 5000: max continuous ticks in KICK+RUN before forced cooldown.
- COOLDOWN_MS, 1000: ticks of forced off after the limit trips.

Ports:
- clk_74a, in, 1: sole clock.
- reset, in, 1: synchronous, active-high reset.
- active, in, 1: level request for continuous rumble.
- intensity, in, PWM_BITS: duty; 0 = no demand.
- pulse_start, in, 1: one-cycle strobe that loads pulse_ms.
- pulse_ms, in, 16: pulse length in ticks; 0 cancels the pending pulse.
- busy, out, 1: state != IDLE.
- cooldown, out, 1: state == COOLDOWN.
- cart_tran_bank0, out, [7:4]: {z, wr_n, z, z}.
- cart_tran_bank1, cart_tran_bank2, out, 8: all z.
- cart_tran_bank3, out, 8: {6×z, ad1, z}.
- cart_tran_bank0_dir = 1, bank3_dir = 1, bank1_dir = 0, bank2_dir = 0: constants.

## Operation
- Timebase: tick_cnt counts 0..TICK_CYCLES-1, free-running from reset. tick = 1 for one cycle when tick_cnt == TICK_CYCLES-1.
- Pulse timer (pulse_rem, 16 bits):
  - pulse_start loads pulse_ms, overriding any running pulse.
  - Otherwise pulse_rem decrements on tick while nonzero, in every state including COOLDOWN.
  - If load and tick coincide, the load wins.
- demand = (active | pulse_rem != 0) & (intensity != 0).
- FSM states: IDLE, KICK, RUN, COOLDOWN.
  - IDLE: demand → KICK, or → RUN if KICK_MS = 0. Clears kick_cnt and on_cnt.
  - KICK: check in priority order:
    - !demand → IDLE.
    - on_cnt reaches MAX_ON_MS → COOLDOWN.
    - kick_cnt reaches KICK_MS → RUN.
  - RUN: !demand → IDLE; on_cnt reaches MAX_ON_MS → COOLDOWN.
  - COOLDOWN: cd_cnt reaches COOLDOWN_MS → IDLE. Demand is ignored here; it is re-evaluated in IDLE on the next cycle.
- Counters (all increment on tick only, and each clears on entry to its state):
  - kick_cnt: in KICK.
  - on_cnt: in KICK and RUN; it is not cleared on the KICK→RUN transition.
  - cd_cnt: in COOLDOWN.
- PWM:
  - pwm_cnt (PWM_BITS) increments every cycle and wraps.
  - drive_on = KICK | (RUN & pwm_cnt < intensity).
  - Maximum intensity therefore yields a duty of (2^PWM_BITS-1)/2^PWM_BITS.
- Pin registers (updated every cycle):
  - wr_n <= ~drive_on.
  - ad1 <= drive_on ? ~ad1 : 0, i.e. the carrier toggles at clk/2 while driving.
- A change of intensity takes effect at the next comparison; there is no glitch filtering.

## Timing
- Reset values: state IDLE; all counters 0; pulse_rem 0; wr_n 1; ad1 0; busy 0; cooldown 0.
- Reset asserted mid-operation returns to these values at the next edge; any pending pulse is lost.
- Latency: demand first true at edge N → state updates at N+1 → wr_n/ad1 change at N+2. The same 2-cycle latency applies to demand removal.
- busy and cooldown are registered state decodes, valid 1 cycle after the transition edge.
- Timer granularity is one tick. KICK lasts between KICK_MS-1 and KICK_MS ticks depending on tick phase at entry. The same bound applies to the MAX_ON and COOLDOWN durations.
- Widths:
  - kick_cnt, on_cnt and cd_cnt are sized with $clog2(param+1); they saturate, never wrap.
  - tick_cnt is sized with $clog2(TICK_CYCLES).

## Test plan
Bench parameters for all scenarios: PWM_BITS=4, TICK_CYCLES=10, KICK_MS=2, MAX_ON_MS=20, COOLDOWN_MS=5.

- Reset/idle: hold reset 3 cycles → wr_n=1, ad1=0, busy=0, banks 1/2 all z, dir pins 1/0/0/1.
- Kick then PWM: active=1, intensity=4 → wr_n low and ad1 toggling 2 cycles later, continuously for ~2 ticks. Then per 16-cycle period, wr_n is low for exactly 4 cycles and ad1 toggles only within them.
- Pulse: active=0, intensity=15, pulse_start with pulse_ms=7 → busy 1 cycle later; returns to IDLE 6–7 ticks later. A second pulse_start with pulse_ms=0 mid-pulse → IDLE within 2 cycles.
- Safety limit: active held at 1 → cooldown=1 after ~20 ticks with wr_n=1. After ~5 ticks → IDLE, and KICK re-enters the next cycle.
- Edge cases:
  - intensity=0 with active=1 → never leaves IDLE.
  - active dropped during KICK → IDLE, pins released 2 cycles later.
  - reset asserted in RUN → all outputs return to reset values next cycle.
